// File: rtl/mul_pipeline_unit_if.sv
// Request/result handshake bundle for the pipelined RV32M multiply unit.
// The unit sits on the slave modport; the issuing side uses master.
interface mul_pipeline_unit_if #(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 6
);
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           in_op;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_result;
  logic [TAG_WIDTH-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/mul_pipeline_unit.sv
// Fully pipelined RV32M multiplier (MUL/MULH/MULHSU/MULHU), one op per cycle,
// fixed STAGES-edge latency from accept to registered result, whole-pipe stall and flush.
module mul_pipeline_unit #(
  parameter int WIDTH     = 32,
  parameter int STAGES    = 3,
  parameter int TAG_WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  mul_pipeline_unit_if.slave bus
);
  localparam int W1   = WIDTH + 1;
  localparam int PW   = 2 * WIDTH;
  localparam int CH   = (W1 + 2) / 3;
  localparam int TOPW = W1 - 2 * CH;

  logic stall;
  logic advance;

  assign stall        = bus.out_valid && !bus.out_ready;
  assign advance      = !stall;
  assign bus.in_ready = !stall && !flush;

  // Operand extension to WIDTH+1 bits so every op becomes one signed multiply.
  logic          a_signed;
  logic          b_signed;
  logic [W1-1:0] a_ext;
  logic [W1-1:0] b_ext;

  always_comb begin
    a_signed = (bus.in_op != 2'b11);
    b_signed = !bus.in_op[1];
    a_ext    = {a_signed & bus.in_a[WIDTH-1], bus.in_a};
    b_ext    = {b_signed & bus.in_b[WIDTH-1], bus.in_b};
  end

  // Stage registers: stage 1 holds extended operands, stages 2..STAGES hold
  // three PW-bit vectors whose sum is the product.
  logic                 valid_reg [1:STAGES];
  logic [1:0]           op_reg    [1:STAGES];
  logic [TAG_WIDTH-1:0] tag_reg   [1:STAGES];
  logic [W1-1:0]        a_reg;
  logic [W1-1:0]        b_reg;
  logic [PW-1:0]        x_reg     [2:STAGES];
  logic [PW-1:0]        y_reg     [2:STAGES];
  logic [PW-1:0]        z_reg     [2:STAGES];
  logic [PW-1:0]        x_next    [2:STAGES];
  logic [PW-1:0]        y_next    [2:STAGES];
  logic [PW-1:0]        z_next    [2:STAGES];

  // Partial products: b split into two unsigned low chunks and a signed top chunk.
  logic [PW-1:0] a_w;
  logic [PW-1:0] b_lo;
  logic [PW-1:0] b_mid;
  logic [PW-1:0] b_hi;
  logic [PW-1:0] pp0;
  logic [PW-1:0] pp1;
  logic [PW-1:0] pp2;

  always_comb begin
    a_w   = {{(PW-W1){a_reg[W1-1]}}, a_reg};
    b_lo  = {{(PW-CH){1'b0}}, b_reg[CH-1:0]};
    b_mid = {{(PW-CH){1'b0}}, b_reg[2*CH-1:CH]};
    b_hi  = {{(PW-TOPW){b_reg[W1-1]}}, b_reg[W1-1:2*CH]};
    pp0   = a_w * b_lo;
    pp1   = (a_w * b_mid) << CH;
    pp2   = (a_w * b_hi) << (2 * CH);
  end

  generate
    for (genvar gi = 2; gi <= STAGES; gi++) begin : gen_stage
      if (gi == 2) begin : gen_pp
        assign x_next[gi] = pp0;
        assign y_next[gi] = pp1;
        assign z_next[gi] = pp2;
      end else begin : gen_csa
        assign x_next[gi] = x_reg[gi-1] ^ y_reg[gi-1] ^ z_reg[gi-1];
        assign y_next[gi] = ((x_reg[gi-1] & y_reg[gi-1]) |
                             (x_reg[gi-1] & z_reg[gi-1]) |
                             (y_reg[gi-1] & z_reg[gi-1])) << 1;
        assign z_next[gi] = '0;
      end
    end
  endgenerate

  // Last stage: one more 3:2 step, carry-propagate add, then pick the half.
  logic [PW-1:0]    fin_sum;
  logic [PW-1:0]    fin_carry;
  logic [PW-1:0]    product;
  logic [WIDTH-1:0] result_next;

  always_comb begin
    fin_sum     = x_reg[STAGES] ^ y_reg[STAGES] ^ z_reg[STAGES];
    fin_carry   = ((x_reg[STAGES] & y_reg[STAGES]) |
                   (x_reg[STAGES] & z_reg[STAGES]) |
                   (y_reg[STAGES] & z_reg[STAGES])) << 1;
    product     = fin_sum + fin_carry;
    result_next = (op_reg[STAGES] == 2'b00) ? product[WIDTH-1:0] : product[PW-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 1; i <= STAGES; i++) valid_reg[i] <= 1'b0;
    end else if (advance) begin
      valid_reg[1] <= bus.in_valid;
      for (int i = 2; i <= STAGES; i++) valid_reg[i] <= valid_reg[i-1];
    end
  end

  // Datapath content of empty stages is don't-care, so no reset here.
  always_ff @(posedge clk) begin
    if (advance) begin
      a_reg      <= a_ext;
      b_reg      <= b_ext;
      op_reg[1]  <= bus.in_op;
      tag_reg[1] <= bus.in_tag;
      for (int i = 2; i <= STAGES; i++) begin
        op_reg[i]  <= op_reg[i-1];
        tag_reg[i] <= tag_reg[i-1];
        x_reg[i]   <= x_next[i];
        y_reg[i]   <= y_next[i];
        z_reg[i]   <= z_next[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      bus.out_tag    <= '0;
    end else if (flush) begin
      bus.out_valid  <= 1'b0;
    end else if (advance) begin
      bus.out_valid  <= valid_reg[STAGES];
      bus.out_result <= result_next;
      bus.out_tag    <= tag_reg[STAGES];
    end
  end
endmodule

// File: tb/tb_mul_pipeline_unit.sv
// Directed bench for mul_pipeline_unit: corner products, latency, streaming,
// backpressure, flush and mid-operation reset, plus a small random batch.
module tb_mul_pipeline_unit;
  localparam int WIDTH     = 32;
  localparam int TAG_WIDTH = 6;
  localparam int STAGES    = 3;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic flush = 1'b0;

  mul_pipeline_unit_if #(.WIDTH(WIDTH), .TAG_WIDTH(TAG_WIDTH)) bus ();

  mul_pipeline_unit #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_WIDTH(TAG_WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [TAG_WIDTH-1:0] got_tag [$];
  logic [WIDTH-1:0]     got_res [$];
  int                   got_cyc [$];
  logic [WIDTH-1:0]     exp_res [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Results handed over at the next rising edge.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      got_tag.push_back(bus.out_tag);
      got_res.push_back(bus.out_result);
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [WIDTH-1:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
    logic signed [65:0] ae;
    logic signed [65:0] be;
    logic signed [65:0] p;
    ae = (op == 2'b11) ? {34'b0, a} : {{34{a[31]}}, a};
    be = op[1] ? {34'b0, b} : {{34{b[31]}}, b};
    p  = ae * be;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
    $display("vec %0d %s: observed %0h expected %0h", vectors, name, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_WIDTH-1:0] tag);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
  endtask

  task automatic clear_log();
    got_tag.delete();
    got_res.delete();
    got_cyc.delete();
  endtask

  // Caller has just passed the accept edge; counts edges until out_valid.
  task automatic wait_result(input string name, input logic [31:0] er, input logic [TAG_WIDTH-1:0] et);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 10) begin
      step();
      n++;
      @(negedge clk);
    end
    check({name, "_latency"}, 64'(n), 64'(STAGES));
    check({name, "_result"}, bus.out_result, er);
    check({name, "_tag"}, bus.out_tag, et);
  endtask

  task automatic run_one(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_WIDTH-1:0] tag, input logic [31:0] er);
    drive(op, a, b, tag);
    step();
    bus.in_valid = 1'b0;
    wait_result(name, er, tag);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    // Reset and idle state.
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_result", bus.out_result, 0);
    check("rst_out_tag", bus.out_tag, 0);
    check("rst_in_ready", bus.in_ready, 1);
    step();
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", bus.in_ready, 0);
    step();
    flush = 1'b0;

    // Directed corner products.
    run_one("mulhu_ff", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd1, 32'hFFFFFFFE);
    run_one("mulh_min", 2'b01, 32'h80000000, 32'h80000000, 6'd2, 32'h40000000);
    run_one("mulh_m1", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd3, 32'h00000000);
    run_one("mulhsu_ff", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd4, 32'hFFFFFFFF);
    run_one("mul_min", 2'b00, 32'h80000000, 32'hFFFFFFFF, 6'd5, 32'h80000000);
    run_one("mul_small", 2'b00, 32'd7, 32'd6, 6'd6, 32'd42);
    run_one("mul_zero", 2'b00, 32'h0, 32'h12345678, 6'd7, 32'h0);
    run_one("mulhsu_min", 2'b10, 32'h80000000, 32'h80000000, 6'd8, 32'hC0000000);
    run_one("mulh_mix", 2'b01, 32'h7FFFFFFF, 32'h80000000, 6'd9, 32'hC0000000);
    run_one("mulhu_two", 2'b11, 32'h80000000, 32'h00000002, 6'd10, 32'h00000001);
    step();

    // Back-to-back stream, tags 0..7.
    clear_log();
    for (int i = 0; i < 8; i++) begin
      drive(2'b00, 32'(i + 1), 32'd3, 6'(i));
      step();
    end
    bus.in_valid = 1'b0;
    repeat (STAGES + 3) step();
    check("b2b_count", 64'(got_tag.size()), 64'd8);
    for (int i = 0; i < 8 && i < got_tag.size(); i++) begin
      check("b2b_tag", got_tag[i], 64'(i));
      check("b2b_result", got_res[i], 64'((i + 1) * 3));
      check("b2b_gap", 64'(got_cyc[i] - got_cyc[0]), 64'(i));
    end

    // Random batch against the reference model.
    clear_log();
    exp_res.delete();
    for (int i = 0; i < 16; i++) begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if (i == 0) a = 32'h80000000;
      if (i == 1) b = 32'h7FFFFFFF;
      exp_res.push_back(ref_mul(op, a, b));
      drive(op, a, b, 6'(16 + i));
      step();
    end
    bus.in_valid = 1'b0;
    repeat (STAGES + 3) step();
    check("rand_count", 64'(got_tag.size()), 64'd16);
    for (int i = 0; i < 16 && i < got_tag.size(); i++) begin
      check("rand_tag", got_tag[i], 64'(16 + i));
      check("rand_result", got_res[i], exp_res[i]);
    end

    // Backpressure: hold the first result for 5 cycles.
    clear_log();
    for (int i = 0; i < 4; i++) begin
      drive(2'b00, 32'(100 + i), 32'd2, 6'(40 + i));
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_result", bus.out_result, 32'd200);
      check("bp_tag", bus.out_tag, 6'd40);
      step();
    end
    bus.out_ready = 1'b1;
    repeat (STAGES + 4) step();
    check("bp_count", 64'(got_tag.size()), 64'd4);
    for (int i = 0; i < 4 && i < got_tag.size(); i++) begin
      check("bp_drain_tag", got_tag[i], 64'(40 + i));
      check("bp_drain_result", got_res[i], 64'(2 * (100 + i)));
    end

    // Flush with three ops in flight; a request during the flush is refused.
    clear_log();
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 32'd11, 32'(i + 1), 6'(60 + i));
      step();
    end
    drive(2'b00, 32'd13, 32'd13, 6'd63);
    flush = 1'b1;
    @(negedge clk);
    check("fl_in_ready", bus.in_ready, 0);
    step();
    flush = 1'b0;
    drive(2'b00, 32'd5, 32'd5, 6'd9);
    @(negedge clk);
    check("fl_out_valid", bus.out_valid, 0);
    step();
    bus.in_valid = 1'b0;
    wait_result("fl_new", 32'd25, 6'd9);
    repeat (STAGES + 3) step();
    check("fl_count", 64'(got_tag.size()), 64'd1);
    if (got_tag.size() > 0) check("fl_only_tag", got_tag[0], 6'd9);

    // Reset (together with flush) while the pipe is full.
    for (int i = 0; i < 4; i++) begin
      drive(2'b01, 32'hDEAD0000, 32'(i + 7), 6'(50 + i));
      step();
    end
    bus.in_valid = 1'b0;
    rst   = 1'b1;
    flush = 1'b1;
    step();
    rst   = 1'b0;
    flush = 1'b0;
    clear_log();
    @(negedge clk);
    check("mrst_out_valid", bus.out_valid, 0);
    check("mrst_out_result", bus.out_result, 0);
    check("mrst_out_tag", bus.out_tag, 0);
    check("mrst_in_ready", bus.in_ready, 1);
    repeat (STAGES + 3) step();
    check("mrst_no_stale", 64'(got_tag.size()), 64'd0);
    check("mrst_idle_valid", bus.out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
